// File: rtl/ram2_ctrl.sv
// ram2_ctrl: arbitrates the single RAM2 port between IF fetches and MEM loads/stores.
// Optional macro RAM2_WBUF_EN adds a one-entry posted write buffer.
module ram2_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RAM_AW = 14
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_pc,
   output logic [DATA_W-1:0] o_if_inst,
   output logic              o_if_valid,
   input  logic              i_mem_req,
   input  logic              i_mem_wr,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] o_mem_rdata,
   output logic              o_mem_done,
   output logic              o_stall_req,
   output logic [ADDR_W-1:0] o_ram_pc,
   input  logic [DATA_W-1:0] i_ram_inst,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_ram_ce,
   output logic              o_ram_re,
   output logic              o_ram_we,
   output logic [2:0]        o_dbg_state
);

   // Handshake: the MEM stage raises i_mem_req with wr/addr/wdata and holds them
   // stable until o_mem_done is high for one cycle; it then drops or changes the request.
   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_DRD   = 3'd1,
      S_DWR1  = 3'd2,
      S_DWR2  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_if_inst;
   logic                r_if_valid;
   logic [DATA_W-1:0]   r_mem_rdata;
   logic                w_fetch;
   logic [RAM_AW-1:0]   w_addr_lo;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_unused_addr_hi;

   assign w_unused_addr_hi = ^i_mem_addr[ADDR_W-1:RAM_AW];

`ifdef RAM2_WBUF_EN
   logic                r_wb_valid;
   logic [RAM_AW-1:0]   r_wb_addr;
   logic [DATA_W-1:0]   r_wb_data;
   logic                w_wb_accept;
   logic                w_wb_clear;
   logic                w_wb_hit;

   assign w_wb_hit = (i_if_pc[RAM_AW-1:0] == r_wb_addr);
`endif

   always_comb begin
      w_next      = r_state;
      o_ram_ce    = 1'b0;
      o_ram_re    = 1'b0;
      o_ram_we    = 1'b0;
      o_mem_done  = 1'b0;
      o_stall_req = 1'b0;
      w_fetch     = 1'b0;
`ifdef RAM2_WBUF_EN
      w_wb_accept = 1'b0;
      w_wb_clear  = 1'b0;
`endif
      case (r_state)
         S_FETCH: begin
`ifdef RAM2_WBUF_EN
            // Drain takes priority whenever someone would otherwise see stale RAM2 contents.
            if (r_wb_valid && (!i_if_req || i_mem_req || w_wb_hit)) begin
               w_next      = S_DWR1;
               o_stall_req = i_mem_req | i_if_req;
            end else if (i_mem_req && i_mem_wr) begin
               w_wb_accept = 1'b1;
               o_mem_done  = 1'b1;
               w_fetch     = i_if_req;
            end else if (i_mem_req) begin
               w_next      = S_DRD;
               o_stall_req = 1'b1;
            end else begin
               w_fetch     = i_if_req;
            end
`else
            if (i_mem_req) begin
               w_next      = i_mem_wr ? S_DWR1 : S_DRD;
               o_stall_req = 1'b1;
            end else begin
               w_fetch     = i_if_req;
            end
`endif
         end
         S_DRD: begin
            o_ram_ce    = 1'b1;
            o_ram_re    = 1'b1;
            o_stall_req = 1'b1;
            w_next      = S_DONE;
         end
         S_DWR1: begin
            o_ram_ce    = 1'b1;
            o_stall_req = 1'b1;
            w_next      = S_DWR2;
         end
         S_DWR2: begin
            o_ram_ce    = 1'b1;
            o_ram_we    = 1'b1;
            o_stall_req = 1'b1;
`ifdef RAM2_WBUF_EN
            w_wb_clear  = 1'b1;
            w_next      = S_FETCH;
`else
            w_next      = S_DONE;
`endif
         end
         S_DONE: begin
            o_mem_done = 1'b1;
            w_fetch    = i_if_req;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_FETCH;
         r_if_inst   <= '0;
         r_if_valid  <= 1'b0;
         r_mem_rdata <= '0;
      end else begin
         r_state    <= w_next;
         r_if_valid <= w_fetch;
         if (w_fetch) r_if_inst <= i_ram_inst;
         if (r_state == S_DRD) r_mem_rdata <= i_ram_rdata;
      end
   end

`ifdef RAM2_WBUF_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
      end else if (w_wb_accept) begin
         r_wb_valid <= 1'b1;
         r_wb_addr  <= i_mem_addr[RAM_AW-1:0];
         r_wb_data  <= i_mem_wdata;
      end else if (w_wb_clear) begin
         r_wb_valid <= 1'b0;
      end
   end

   // With the buffer present every write cycle drains the buffer, never the live request.
   assign w_addr_lo = (r_state == S_DWR1 || r_state == S_DWR2) ? r_wb_addr : i_mem_addr[RAM_AW-1:0];
   assign w_wdata   = (r_state == S_DWR1 || r_state == S_DWR2) ? r_wb_data : i_mem_wdata;
`else
   assign w_addr_lo = i_mem_addr[RAM_AW-1:0];
   assign w_wdata   = i_mem_wdata;
`endif

   assign o_ram_addr  = {{(ADDR_W-RAM_AW){1'b0}}, w_addr_lo};
   assign o_ram_wdata = w_wdata;
   assign o_ram_pc    = i_if_pc;
   assign o_if_inst   = r_if_inst;
   assign o_if_valid  = r_if_valid;
   assign o_mem_rdata = r_mem_rdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb_ram2_ctrl: randomized bench for ram2_ctrl with a RAM2 model and an expected-memory reference.
// Build with +define+RAM2_WBUF_EN to exercise the posted write buffer.
module tb_ram2_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_pc;
   logic [15:0] if_inst;
   logic        if_valid;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        stall_req;
   logic [15:0] ram_pc;
   logic [15:0] ram_inst;
   logic [15:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        ram_ce;
   logic        ram_re;
   logic        ram_we;
   logic [2:0]  unused_dbg_state;

   int total = 0;
   int bad   = 0;

   logic [15:0] ram [0:16383];
   logic [15:0] exp_mem [int];
   logic        bd_we = 1'b0;
   logic [13:0] bd_addr = '0;
   logic [15:0] bd_data = '0;

   always #5 clk = ~clk;

   ram2_ctrl dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_pc(if_pc), .o_if_inst(if_inst), .o_if_valid(if_valid),
      .i_mem_req(mem_req), .i_mem_wr(mem_wr), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
      .o_mem_rdata(mem_rdata), .o_mem_done(mem_done), .o_stall_req(stall_req),
      .o_ram_pc(ram_pc), .i_ram_inst(ram_inst), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata), .o_ram_ce(ram_ce), .o_ram_re(ram_re), .o_ram_we(ram_we),
      .o_dbg_state(unused_dbg_state)
   );

   // RAM2: combinational reads, write on the clock edge while the write strobe is high.
   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (ram_ce && ram_we) ram[ram_addr[13:0]] <= ram_wdata;
   end
   assign ram_inst  = ram[ram_pc[13:0]];
   assign ram_rdata = ram[ram_addr[13:0]];

   task automatic poke(input logic [13:0] a, input logic [15:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      exp_mem[int'(a)] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic run_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                             output int n_stall, output int n_re, output int n_we,
                             output int n_setup, output int n_addr_bad, output int n_ivalid,
                             output int n_overlap, output logic done, output logic [15:0] rdata);
      logic prev_setup;
      n_stall = 0; n_re = 0; n_we = 0; n_setup = 0; n_addr_bad = 0; n_ivalid = 0; n_overlap = 0;
      done = 1'b0; rdata = '0; prev_setup = 1'b0;
      @(negedge clk);
      mem_req = 1'b1; mem_wr = wr; mem_addr = addr; mem_wdata = data;
      if_req = 1'b1; if_pc = 16'(16'h0100 + $urandom_range(0, 15));
      for (int c = 0; c < 16 && !done; c++) begin
         #1;
         if (stall_req) n_stall++;
         if (ram_re) n_re++;
         if (ram_we) begin
            n_we++;
            if (prev_setup) n_setup++;
            if (ram_wdata !== data) n_addr_bad++;
         end
         if (ram_re && ram_we) n_overlap++;
         if ((ram_re || ram_we) && !ram_ce) n_overlap++;
         if (ram_ce && ram_addr !== {2'b00, addr[13:0]}) n_addr_bad++;
         if (c > 0 && if_valid) n_ivalid++;
         prev_setup = ram_ce && !ram_we && !ram_re;
         if (mem_done) begin
            done  = 1'b1;
            rdata = mem_rdata;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      mem_req = 1'b0; mem_wr = 1'b0; if_req = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; if_req = 1'b0; if_pc = '0; mem_req = 1'b0; mem_wr = 1'b0;
      mem_addr = '0; mem_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", ram_ce); end
      total++; if (ram_re !== 1'b0) begin bad++; $display("FAIL reset_re: got %b want 0", ram_re); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      total++; if (mem_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", mem_done); end
      total++; if (if_inst !== 16'h0) begin bad++; $display("FAIL reset_if_inst: got %h want 0000", if_inst); end
      total++; if (mem_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0000", mem_rdata); end
      rst = 1'b0;
   endtask

   task automatic test_fetch;
      logic        prev_req;
      logic [15:0] exp_inst;
      @(negedge clk);
      if_req = 1'b1; if_pc = 16'h0005;
      #1;
      total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL fetch_ce: got %b want 0", ram_ce); end
      @(negedge clk);
      #1;
      total++; if (if_inst !== 16'h6901) begin bad++; $display("FAIL fetch_inst: got %h want 6901", if_inst); end
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid: got %b want 1", if_valid); end
      total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL fetch_ce2: got %b want 0", ram_ce); end
      if_req = 1'b0;
      prev_req = 1'b0; exp_inst = 16'h6901;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         total++; if (if_valid !== prev_req) begin bad++; $display("FAIL rnd_fetch_valid[%0d]: got %b want %b", i, if_valid, prev_req); end
         total++; if (if_inst !== exp_inst) begin bad++; $display("FAIL rnd_fetch_inst[%0d]: got %h want %h", i, if_inst, exp_inst); end
         if_req = 1'($urandom_range(0, 1));
         if_pc  = {2'($urandom_range(0, 3)), 14'(14'h0100 + $urandom_range(0, 15))};
         prev_req = if_req;
         if (if_req) exp_inst = exp_mem[int'(if_pc[13:0])];
         #1;
         total++; if (ram_ce !== 1'b0 || ram_pc !== if_pc) begin bad++; $display("FAIL rnd_fetch_path[%0d]: ce=%b pc=%h want ce=0 pc=%h", i, ram_ce, ram_pc, if_pc); end
      end
      @(negedge clk);
      if_req = 1'b0;
   endtask

   task automatic test_load;
      int n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov;
      logic done;
      logic [15:0] rd;
      run_access(1'b0, 16'h0009, 16'h0000, n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov, done, rd);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL load_done: got %b want 1", done); end
      total++; if (rd !== 16'hE145) begin bad++; $display("FAIL load_data: got %h want e145", rd); end
      total++; if (n_stall != 2) begin bad++; $display("FAIL load_stalls: got %0d want 2", n_stall); end
      total++; if (n_re != 1) begin bad++; $display("FAIL load_re_cycles: got %0d want 1", n_re); end
      total++; if (n_we != 0) begin bad++; $display("FAIL load_we_cycles: got %0d want 0", n_we); end
      total++; if (n_iv != 0) begin bad++; $display("FAIL load_if_valid: got %0d cycles want 0", n_iv); end
      total++; if (n_ov != 0) begin bad++; $display("FAIL load_strobes: got %0d bad cycles want 0", n_ov); end
      total++; if (n_abad != 0) begin bad++; $display("FAIL load_addr: got %0d bad cycles want 0", n_abad); end
   endtask

   task automatic test_store;
      int n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov;
      logic done;
      logic [15:0] rd;
      run_access(1'b1, 16'h4020, 16'h1234, n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov, done, rd);
      exp_mem[int'(14'h0020)] = 16'h1234;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL store_done: got %b want 1", done); end
`ifndef RAM2_WBUF_EN
      total++; if (n_stall != 3) begin bad++; $display("FAIL store_stalls: got %0d want 3", n_stall); end
      total++; if (n_we != 1) begin bad++; $display("FAIL store_we_cycles: got %0d want 1", n_we); end
      total++; if (n_setup != 1) begin bad++; $display("FAIL store_setup: got %0d want 1", n_setup); end
      total++; if (n_re != 0) begin bad++; $display("FAIL store_re_cycles: got %0d want 0", n_re); end
      total++; if (n_abad != 0) begin bad++; $display("FAIL store_addr_data: got %0d bad cycles want 0", n_abad); end
      total++; if (n_iv != 0) begin bad++; $display("FAIL store_if_valid: got %0d cycles want 0", n_iv); end
`else
      total++; if (n_stall != 0) begin bad++; $display("FAIL wbuf_store_stalls: got %0d want 0", n_stall); end
`endif
      total++; if (n_ov != 0) begin bad++; $display("FAIL store_strobes: got %0d bad cycles want 0", n_ov); end
      run_access(1'b0, 16'h0020, 16'h0000, n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov, done, rd);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL readback_done: got %b want 1", done); end
      total++; if (rd !== 16'h1234) begin bad++; $display("FAIL readback_data: got %h want 1234", rd); end
   endtask

   task automatic test_random;
      int n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov;
      logic done;
      logic [15:0] rd, a, d;
      logic wr;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = {2'($urandom_range(0, 3)), 14'(14'h0100 + $urandom_range(0, 15))};
         d  = 16'($urandom_range(0, 65535));
         run_access(wr, a, d, n_stall, n_re, n_we, n_setup, n_abad, n_iv, n_ov, done, rd);
         total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd_done[%0d]: got %b want 1", i, done); end
         total++; if (n_ov != 0) begin bad++; $display("FAIL rnd_strobes[%0d]: got %0d bad cycles want 0", i, n_ov); end
         if (wr) begin
            exp_mem[int'(a[13:0])] = d;
         end else begin
            total++; if (rd !== exp_mem[int'(a[13:0])]) begin bad++; $display("FAIL rnd_load[%0d]: addr %h got %h want %h", i, a, rd, exp_mem[int'(a[13:0])]); end
         end
`ifndef RAM2_WBUF_EN
         total++; if (n_stall != (wr ? 3 : 2)) begin bad++; $display("FAIL rnd_stalls[%0d]: got %0d want %0d", i, n_stall, wr ? 3 : 2); end
         total++; if (n_abad != 0) begin bad++; $display("FAIL rnd_addr[%0d]: got %0d bad cycles want 0", i, n_abad); end
`endif
      end
   endtask

`ifndef RAM2_WBUF_EN
   task automatic test_reset_mid;
      int stray_done;
      @(negedge clk);
      mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0130; mem_wdata = 16'hA5A5; if_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL rstmid_we_before: got %b want 1", ram_we); end
      rst = 1'b1; mem_req = 1'b0; mem_wr = 1'b0;
      @(negedge clk);
      #1;
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rstmid_we_after: got %b want 0", ram_we); end
      total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL rstmid_ce_after: got %b want 0", ram_ce); end
      stray_done = mem_done ? 1 : 0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (mem_done) stray_done++;
      end
      total++; if (stray_done != 0) begin bad++; $display("FAIL rstmid_done: got %0d pulses want 0", stray_done); end
   endtask
`else
   task automatic test_wbuf_fetch;
      int n_stall;
      logic got;
      @(negedge clk);
      mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0005; mem_wdata = 16'hBEEF;
      if_req = 1'b1; if_pc = 16'h0100;
      #1;
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL wbuf_accept_stall: got %b want 0", stall_req); end
      total++; if (mem_done !== 1'b1) begin bad++; $display("FAIL wbuf_accept_done: got %b want 1", mem_done); end
      @(negedge clk);
      mem_req = 1'b0; mem_wr = 1'b0; if_pc = 16'h0005;
      n_stall = 0; got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         #1;
         if (stall_req) n_stall++;
         @(negedge clk);
         #1;
         if (if_valid && if_pc == 16'h0005) got = 1'b1;
      end
      total++; if (got !== 1'b1) begin bad++; $display("FAIL wbuf_fetch_valid: got %b want 1", got); end
      total++; if (if_inst !== 16'hBEEF) begin bad++; $display("FAIL wbuf_fetch_inst: got %h want beef", if_inst); end
      total++; if (n_stall < 2) begin bad++; $display("FAIL wbuf_fetch_held: got %0d stall cycles want >=2", n_stall); end
      if_req = 1'b0;
   endtask
`endif

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      poke(14'h0005, 16'h6901);
      poke(14'h0009, 16'hE145);
      for (int i = 0; i < 16; i++) poke(14'(14'h0100 + i), 16'($urandom_range(0, 65535)));
      test_fetch;
      test_load;
      test_store;
      test_random;
`ifndef RAM2_WBUF_EN
      test_reset_mid;
`else
      test_wbuf_fetch;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
